ctr_keystream_gen: RTL and testbench
====================================

# ctr_keystream_gen

Keystream source for the GCM CTR datapath. It loads the pre-counter block J0, encrypts J0 once through the shared AES core to produce the tag mask E(K,J0), then prefetches E(K,inc32^n(J0)) blocks into a small in-order FIFO. The CTR XOR stage pops these blocks from the FIFO. The block sits between the AES core and the CTR XOR stage, and owns all counter arithmetic.

## Interface
Parameters:
- DEPTH, 2, keystream FIFO depth in blocks (power of two, ≥2); also bounds prefetch.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; loads j0 and begins a message; honoured only when busy=0
- abort  in  1  pulse; ends current message, flushes FIFO; ignored when busy=0
- j0  in  128  pre-counter block, sampled on accepted start
- busy  out  1  high from accepted start until return to IDLE
- tag_mask_valid  out  1  high once E(K,J0) captured; cleared by start/abort
- tag_mask  out  128  E(K,J0)
- aes_in_valid  out  1  request to AES core
- aes_in_ready  in  1  AES core accepts on valid&&ready
- aes_in_block  out  128  counter block to encrypt
- aes_out_valid  in  1  single-cycle result pulse, in request order, no backpressure
- aes_out_block  in  128  encrypted block
- ks_valid  out  1  FIFO non-empty
- ks_ready  in  1  consumer pops head on ks_valid&&ks_ready
- ks_data  out  128  FIFO head

## Operation
- States:
  - IDLE: busy=0. Accepted start → MASK.
  - MASK: aes_in_valid=1 with aes_in_block=J0. On handshake: ctr←inc32(J0), mask_pending←1, inflight+1 → RUN.
  - RUN: aes_in_valid=1 iff (fifo_count + inflight − mask_pending) < DEPTH, with aes_in_block=ctr. On handshake: ctr←inc32(ctr), inflight+1.
  - DRAIN: aes_in_valid=0. Every aes_out_valid is discarded. When inflight=0 → IDLE.
- abort in MASK or RUN: FIFO cleared, mask_pending←0, tag_mask_valid←0. Go to DRAIN if inflight>0 after this cycle's return, otherwise IDLE.
- A start that arrives during busy is ignored, as is an abort that arrives during IDLE. If start and abort arrive together, abort rules.
- inc32: low 32 bits +1 mod 2^32. Bits [127:32] never change. Wrap 0xFFFFFFFF→0x00000000 with no carry.
- aes_out_valid handling:
  - mask_pending=1: captured into tag_mask; tag_mask_valid←1, mask_pending←0.
  - Otherwise, in RUN: pushed to FIFO tail.
  - Every return decrements inflight.
- Space is reserved at issue, so a push never overflows. An aes_out_valid with inflight=0 is a protocol violation and is ignored.
- FIFO push and pop in the same cycle are both performed; count is unchanged.
- The message ends only via abort. The controller issues abort after the last block is consumed or the tag is done. Surplus prefetched blocks are discarded.

## Timing
- Reset values: busy=0, tag_mask_valid=0, tag_mask=0, aes_in_valid=0, aes_in_block=0, ks_valid=0, ks_data=0. Internal state: IDLE, inflight=0, FIFO empty.
- start at cycle t → busy=1 and aes_in_valid=1 (J0) at t+1.
- Next request follows the MASK handshake by one cycle, provided space is available.
- aes_out_valid at cycle t → FIFO entry visible on ks_valid/ks_data at t+1. tag_mask_valid rises at t+1.
- aes_in_valid is registered. While aes_in_ready=0, aes_in_valid and aes_in_block hold stable.
- Pop at t → next head (or ks_valid=0) at t+1. A freed slot can be re-requested at t+1.
- abort at t → ks_valid=0 and tag_mask_valid=0 at t+1. aes_in_valid=0 from t+1.
- Reset asserted mid-operation returns all outputs to reset values immediately. AES responses arriving after reset release are ignored.

## Test plan
- Basic: stub AES = block ^ 0xA5…A5, latency 3, ks_ready=1. Stimulus: start with j0=0x…CAFE_00000001. Required response:
  - aes_in_block sequence …00000001, …00000002, …00000003.
  - tag_mask = j0^0xA5…A5.
  - ks_data = (…02)^A5…, then (…03)^A5….
- Backpressure: ks_ready=0, DEPTH=2. Required: exactly 3 requests issued (mask + 2), aes_in_valid then stays 0, ks_valid=1. One pop → exactly one new request on the next cycle.
- Wrap: j0 low32=0xFFFFFFFE. Required: requests …FFFFFFFE, …FFFFFFFF, …00000000, with bits [127:32] unchanged.
- AES stall: aes_in_ready=0 for 5 cycles. Required: aes_in_valid and aes_in_block stable, no counter advance, no duplicate or missing counter.
- Abort with 2 in flight. Required:
  - ks_valid and tag_mask_valid = 0 next cycle.
  - busy stays 1 until the second response returns, then falls.
  - Both responses discarded.
  - A following start with a new j0 yields a correct tag_mask.
- Reset mid-RUN: rst_n low for 1 cycle. Required: all outputs at reset values, start accepted next cycle, late AES pulse ignored.

Source files
------------

// File: rtl/ctr_keystream_gen.sv
// rtl/ctr_keystream_gen.sv - GCM CTR keystream source: tag mask E(K,J0) plus prefetched keystream FIFO
module ctr_keystream_gen #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] j0,
  output logic         busy,
  output logic         tag_mask_valid,
  output logic [127:0] tag_mask,
  output logic         aes_in_valid,
  input  logic         aes_in_ready,
  output logic [127:0] aes_in_block,
  input  logic         aes_out_valid,
  input  logic [127:0] aes_out_block,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [127:0] ks_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int W  = $clog2(DEPTH + 2) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MASK, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [127:0]    ctr_q, ctr_d;
  logic [W-1:0]    inflight_q, inflight_d;
  logic            mask_pending_q, mask_pending_d;
  logic            tmv_q, tmv_d;
  logic [127:0]    tag_mask_q, tag_mask_d;
  logic            aes_in_valid_q, aes_in_valid_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [127:0]    mem_q [DEPTH];
  logic            fire, ret, push, pop, flush;
  logic [W:0]      occ_d;

  // Only the low 32 bits count; the upper 96 bits of the block are fixed.
  function automatic logic [127:0] inc32(input logic [127:0] v);
    return {v[127:32], v[31:0] + 32'd1};
  endfunction

  // A return with nothing outstanding is a protocol violation and is dropped.
  assign fire = aes_in_valid_q && aes_in_ready;
  assign ret  = aes_out_valid && (inflight_q != '0);

  assign busy           = (state_q != S_IDLE);
  assign tag_mask_valid = tmv_q;
  assign tag_mask       = tag_mask_q;
  assign aes_in_valid   = aes_in_valid_q;
  assign aes_in_block   = ctr_q;
  assign ks_valid       = (count_q != '0);
  assign ks_data        = ks_valid ? mem_q[rd_ptr_q] : '0;

  // Next-state: sequencing, counter advance, result routing and request qualification.
  always_comb begin
    state_d        = state_q;
    ctr_d          = ctr_q;
    inflight_d     = inflight_q;
    mask_pending_d = mask_pending_q;
    tmv_d          = tmv_q;
    tag_mask_d     = tag_mask_q;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;

    if (fire) begin
      ctr_d      = inc32(ctr_q);
      inflight_d = inflight_d + W'(1);
    end
    if (ret) inflight_d = inflight_d - W'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d        = S_MASK;
          ctr_d          = j0;
          tmv_d          = 1'b0;
          mask_pending_d = 1'b0;
        end
      end
      S_MASK, S_RUN: begin
        if (abort) begin
          flush          = 1'b1;
          mask_pending_d = 1'b0;
          tmv_d          = 1'b0;
          state_d        = (inflight_d != '0) ? S_DRAIN : S_IDLE;
        end else begin
          if (ret && mask_pending_q) begin
            tag_mask_d     = aes_out_block;
            tmv_d          = 1'b1;
            mask_pending_d = 1'b0;
          end else if (ret && state_q == S_RUN) begin
            push = 1'b1;
          end
          pop = ks_valid && ks_ready;
          if (state_q == S_MASK && fire) begin
            mask_pending_d = 1'b1;
            state_d        = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      if (push && !pop) count_d = count_q + W'(1);
      else if (pop && !push) count_d = count_q - W'(1);
    end

    // Slots are reserved at issue; the outstanding mask request owns no FIFO slot.
    occ_d = {1'b0, count_d} + {1'b0, inflight_d} - {{W{1'b0}}, mask_pending_d};
    aes_in_valid_d = (state_d == S_MASK) ||
                     ((state_d == S_RUN) && (occ_d < (W+1)'(DEPTH)));
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ctr_q          <= '0;
      inflight_q     <= '0;
      mask_pending_q <= 1'b0;
      tmv_q          <= 1'b0;
      tag_mask_q     <= '0;
      aes_in_valid_q <= 1'b0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      inflight_q     <= inflight_d;
      mask_pending_q <= mask_pending_d;
      tmv_q          <= tmv_d;
      tag_mask_q     <= tag_mask_d;
      aes_in_valid_q <= aes_in_valid_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  // Keystream storage; contents are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= aes_out_block;
  end

endmodule

// File: tb/tb_ctr_keystream_gen.sv
// tb/tb_ctr_keystream_gen.sv - directed scoreboard bench for ctr_keystream_gen
module tb_ctr_keystream_gen;

  localparam logic [127:0] A5       = {16{8'hA5}};
  localparam logic [127:0] J_BASIC  = 128'h0123456789ABCDEF0000CAFE00000001;
  localparam logic [127:0] J_BASIC2 = 128'h0123456789ABCDEF0000CAFE00000002;
  localparam logic [127:0] J_BASIC3 = 128'h0123456789ABCDEF0000CAFE00000003;
  localparam logic [127:0] J_WRAP   = 128'hDEADBEEF0000111122223333FFFFFFFE;
  localparam logic [127:0] J_WRAP2  = 128'hDEADBEEF0000111122223333FFFFFFFF;
  localparam logic [127:0] J_WRAP3  = 128'hDEADBEEF000011112222333300000000;
  localparam logic [127:0] J_STALL  = 128'h11112222333344445555666700000100;
  localparam logic [127:0] J_STALL2 = 128'h11112222333344445555666700000101;
  localparam logic [127:0] J_BP     = 128'h0F0E0D0C0B0A09080706050400000010;
  localparam logic [127:0] J_BP2    = 128'h0F0E0D0C0B0A09080706050400000011;
  localparam logic [127:0] J_AB     = 128'hABCDABCDABCDABCDABCDABCD00000020;
  localparam logic [127:0] J_AB2    = 128'h5555AAAA5555AAAA5555AAAA00000030;
  localparam logic [127:0] J_RST    = 128'h99998888777766665555444400000040;
  localparam logic [127:0] J_RST2   = 128'h1234123412341234123412347FFFFFF0;
  localparam logic [127:0] J_RST2N  = 128'h1234123412341234123412347FFFFFF1;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, aes_in_ready, aes_out_valid, ks_ready;
  logic [127:0] j0, aes_out_block;
  logic         busy, tag_mask_valid, aes_in_valid, ks_valid;
  logic [127:0] tag_mask, aes_in_block, ks_data;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0, lat = 3, stub_c;

  typedef struct { logic [127:0] data; int due; } rsp_t;
  rsp_t         stub_q[$];
  rsp_t         rsp;
  logic [127:0] ks_q[$];
  logic [127:0] req_log[$];
  logic [127:0] pop_log[$];
  logic [127:0] exp_ctr = '0;
  logic         expect_mask = 1'b0;

  ctr_keystream_gen #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .j0(j0),
    .busy(busy), .tag_mask_valid(tag_mask_valid), .tag_mask(tag_mask),
    .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_in_block(aes_in_block),
    .aes_out_valid(aes_out_valid), .aes_out_block(aes_out_block),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] inc32(input logic [127:0] v);
    return {v[127:32], v[31:0] + 32'd1};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AES stub: block ^ A5..A5 with programmable latency, in order.
  always @(posedge clk) begin
    if (aes_in_valid && aes_in_ready) begin
      rsp.data = aes_in_block ^ A5;
      rsp.due  = cyc + lat;
      stub_q.push_back(rsp);
    end
    stub_c = cyc;
    cyc++;
    #1;
    if (stub_q.size() > 0 && stub_q[0].due == stub_c + 1) begin
      aes_out_valid = 1'b1;
      aes_out_block = stub_q[0].data;
      void'(stub_q.pop_front());
    end else begin
      aes_out_valid = 1'b0;
      aes_out_block = '0;
    end
  end

  // Scoreboard: requests checked against the counter model; pops against the queue.
  always @(posedge clk) begin
    if (rst_n) begin
      if (aes_in_valid && aes_in_ready) begin
        check("req_ctr", aes_in_block, exp_ctr);
        req_log.push_back(aes_in_block);
        if (expect_mask) expect_mask = 1'b0;
        else ks_q.push_back(exp_ctr ^ A5);
        exp_ctr = inc32(exp_ctr);
      end
      if (ks_valid && ks_ready) begin
        pop_log.push_back(ks_data);
        check("ks_expected_present", 128'(ks_q.size() != 0), 128'd1);
        if (ks_q.size() != 0) check("ks_data", ks_data, ks_q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_tmv"}, 128'(tag_mask_valid), 128'd0);
    check({tag, "_tag"}, tag_mask, 128'd0);
    check({tag, "_aes_v"}, 128'(aes_in_valid), 128'd0);
    check({tag, "_aes_blk"}, aes_in_block, 128'd0);
    check({tag, "_ks_v"}, 128'(ks_valid), 128'd0);
    check({tag, "_ks_data"}, ks_data, 128'd0);
  endtask

  task automatic do_start(input logic [127:0] v);
    j0 = v;
    start = 1'b1;
    exp_ctr = v;
    expect_mask = 1'b1;
    req_log.delete();
    pop_log.delete();
    ks_q.delete();
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 128'(busy), 128'd1);
    check("start_aes_v", 128'(aes_in_valid), 128'd1);
    check("start_aes_blk", aes_in_block, v);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ks_q.delete();
    expect_mask = 1'b0;
    check("abort_ks_v", 128'(ks_valid), 128'd0);
    check("abort_tmv", 128'(tag_mask_valid), 128'd0);
  endtask

  task automatic wait_idle(input int maxc);
    for (int k = 0; k < maxc && busy; k++) @(negedge clk);
    check("idle_timeout", 128'(busy), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; j0 = '0;
    aes_in_ready = 1'b1; ks_ready = 1'b0;
    aes_out_valid = 1'b0; aes_out_block = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic streaming
    ks_ready = 1'b1;
    do_start(J_BASIC);
    repeat (12) @(negedge clk);
    check("basic_tmv", 128'(tag_mask_valid), 128'd1);
    check("basic_tag", tag_mask, J_BASIC ^ A5);
    check("basic_req0", req_log[0], J_BASIC);
    check("basic_req1", req_log[1], J_BASIC2);
    check("basic_req2", req_log[2], J_BASIC3);
    check("basic_pop0", pop_log[0], J_BASIC2 ^ A5);
    check("basic_pop1", pop_log[1], J_BASIC3 ^ A5);
    do_abort();
    wait_idle(20);

    // 32-bit counter wrap
    do_start(J_WRAP);
    repeat (10) @(negedge clk);
    check("wrap_req0", req_log[0], J_WRAP);
    check("wrap_req1", req_log[1], J_WRAP2);
    check("wrap_req2", req_log[2], J_WRAP3);
    check("wrap_tag", tag_mask, J_WRAP ^ A5);
    do_abort();
    wait_idle(20);

    // AES input stall on the mask request
    aes_in_ready = 1'b0;
    do_start(J_STALL);
    for (int i = 0; i < 5; i++) begin
      check("stall_aes_v", 128'(aes_in_valid), 128'd1);
      check("stall_aes_blk", aes_in_block, J_STALL);
      @(negedge clk);
    end
    check("stall_no_req", 128'(req_log.size()), 128'd0);
    aes_in_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("stall_req0", req_log[0], J_STALL);
    check("stall_req1", req_log[1], J_STALL2);
    check("stall_tag", tag_mask, J_STALL ^ A5);
    do_abort();
    wait_idle(20);

    // Keystream backpressure bounds prefetch to DEPTH
    ks_ready = 1'b0;
    do_start(J_BP);
    repeat (10) @(negedge clk);
    check("bp_req_count", 128'(req_log.size()), 128'd3);
    check("bp_aes_v_low", 128'(aes_in_valid), 128'd0);
    check("bp_ks_v", 128'(ks_valid), 128'd1);
    check("bp_ks_head", ks_data, J_BP2 ^ A5);
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    check("bp_refill_v", 128'(aes_in_valid), 128'd1);
    repeat (6) @(negedge clk);
    check("bp_req_count2", 128'(req_log.size()), 128'd4);
    check("bp_aes_v_low2", 128'(aes_in_valid), 128'd0);
    check("bp_pop_count", 128'(pop_log.size()), 128'd1);
    check("bp_pop0", pop_log[0], J_BP2 ^ A5);
    do_abort();
    wait_idle(20);

    // Abort with two requests in flight
    lat = 1;
    do_start(J_AB);
    @(negedge clk);
    lat = 6;
    @(negedge clk);
    check("ab_tmv_pre", 128'(tag_mask_valid), 128'd1);
    @(negedge clk);
    check("ab_req_count", 128'(req_log.size()), 128'd3);
    do_abort();
    check("ab_busy_after", 128'(busy), 128'd1);
    repeat (4) @(negedge clk);
    check("ab_busy_drain", 128'(busy), 128'd1);
    @(negedge clk);
    check("ab_busy_fall", 128'(busy), 128'd0);
    check("ab_ks_discard", 128'(ks_valid), 128'd0);
    check("ab_tmv_discard", 128'(tag_mask_valid), 128'd0);
    lat = 3;
    do_start(J_AB2);
    repeat (8) @(negedge clk);
    check("ab_new_tmv", 128'(tag_mask_valid), 128'd1);
    check("ab_new_tag", tag_mask, J_AB2 ^ A5);
    do_abort();
    wait_idle(20);

    // Reset mid-RUN, late responses must be ignored
    ks_ready = 1'b1;
    do_start(J_RST);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ks_q.delete();
    expect_mask = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(J_RST2);
    repeat (8) @(negedge clk);
    check("rst_tmv", 128'(tag_mask_valid), 128'd1);
    check("rst_tag", tag_mask, J_RST2 ^ A5);
    check("rst_pop0", pop_log[0], J_RST2N ^ A5);
    do_abort();
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
